// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group count helper
// and a propagate/generate pair type for benches and tooling.
package cla_pkg;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Guarded so that an illegal GROUP still elaborates far enough to report it.
    function automatic int ngroups(input int width, input int group);
        return (group > 0) ? (width / group) : 1;
    endfunction

endpackage

// File: rtl/cla_group.sv
// One lookahead group: ripple-style carry recurrence inside the group, group
// propagate/generate out, and the sum bits for a given group carry-in.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             cin,
    output logic             grp_p,
    output logic             grp_g,
    output logic [GROUP-1:0] sum
);

    logic [GROUP-1:0] carry_vec;
    logic [GROUP:0]   gen_vec;

    assign carry_vec[0] = cin;
    assign gen_vec[0]   = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < GROUP; gi++) begin : g_carry
            assign carry_vec[gi] = g[gi-1] | (p[gi-1] & carry_vec[gi-1]);
        end
        // Group generate is the same recurrence evaluated with a zero carry-in.
        for (gi = 0; gi < GROUP; gi++) begin : g_gen
            assign gen_vec[gi+1] = g[gi] | (p[gi] & gen_vec[gi]);
        end
    endgenerate

    assign grp_p = &p;
    assign grp_g = gen_vec[GROUP];
    assign sum   = p ^ carry_vec;

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow
// control: stage 1 registers bit and group P/G, stage 2 resolves carries and sums.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NGRP = ngroups(WIDTH, GROUP);

    generate
        if (GROUP < 1) begin : g_bad_group
            $error("cla_pipe_adder: GROUP must be at least 1");
        end else if ((WIDTH % GROUP) != 0) begin : g_bad_width
            $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
        end
    endgenerate

    // Pipeline state
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_p_reg;
    logic [WIDTH-1:0] s1_g_reg;
    logic [NGRP-1:0]  s1_gp_reg;
    logic [NGRP-1:0]  s1_gg_reg;
    logic             s1_c0_reg;

    logic             s2_valid_reg;
    logic [WIDTH-1:0] out_sum_reg;
    logic             out_cout_reg;
    logic             out_ovf_reg;

    // Handshake: each stage advances when its slot is empty or the next one moves.
    logic adv1;
    logic adv2;

    assign adv2     = !s2_valid_reg | out_ready;
    assign adv1     = !s1_valid_reg | adv2;
    assign in_ready = adv1;

    // Stage 1 combinational
    logic [WIDTH-1:0] bb_next;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] g_next;
    logic             c0_next;
    logic [NGRP-1:0]  gp_next;
    logic [NGRP-1:0]  gg_next;
    logic [WIDTH-1:0] s1_sum_unused;

    assign bb_next = in_sub ? ~in_b : in_b;
    assign c0_next = in_sub | in_cin;
    assign p_next  = in_a ^ bb_next;
    assign g_next  = in_a & bb_next;

    // Stage 2 combinational
    logic [NGRP:0]    c_grp;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             msb_cin;
    logic             ovf_next;
    logic [NGRP-1:0]  s2_gp_unused;
    logic [NGRP-1:0]  s2_gg_unused;

    assign c_grp[0] = s1_c0_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_pg (
                .p     (p_next[gi*GROUP +: GROUP]),
                .g     (g_next[gi*GROUP +: GROUP]),
                .cin   (1'b0),
                .grp_p (gp_next[gi]),
                .grp_g (gg_next[gi]),
                .sum   (s1_sum_unused[gi*GROUP +: GROUP])
            );

            assign c_grp[gi+1] = s1_gg_reg[gi] | (s1_gp_reg[gi] & c_grp[gi]);

            cla_group #(.GROUP(GROUP)) u_sum (
                .p     (s1_p_reg[gi*GROUP +: GROUP]),
                .g     (s1_g_reg[gi*GROUP +: GROUP]),
                .cin   (c_grp[gi]),
                .grp_p (s2_gp_unused[gi]),
                .grp_g (s2_gg_unused[gi]),
                .sum   (sum_next[gi*GROUP +: GROUP])
            );
        end
    endgenerate

    // sum = p ^ carry, so the carry into the MSB falls out of the sum bit.
    assign cout_next = c_grp[NGRP];
    assign msb_cin   = sum_next[WIDTH-1] ^ s1_p_reg[WIDTH-1];
    assign ovf_next  = msb_cin ^ cout_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            out_sum_reg  <= '0;
            out_cout_reg <= 1'b0;
            out_ovf_reg  <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid_reg <= in_valid;
            end
            if (adv2) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_sum_reg  <= sum_next;
                    out_cout_reg <= cout_next;
                    out_ovf_reg  <= ovf_next;
                end
            end
        end
    end

    // Stage 1 data carries no reset; its valid bit alone qualifies it.
    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            s1_p_reg  <= p_next;
            s1_g_reg  <= g_next;
            s1_gp_reg <= gp_next;
            s1_gg_reg <= gg_next;
            s1_c0_reg <= c0_next;
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_cout  = out_cout_reg;
    assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder: reset, hand-computed vectors, backpressure,
// mid-stream reset, back-to-back streaming and a width/group sweep.
module tb_cla_pipe_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Main DUT, WIDTH=32 GROUP=4
    logic        rst_n;
    logic        in_valid, in_ready, in_cin, in_sub;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready, out_cout, out_ovf;
    logic [31:0] out_sum;

    // Sweep DUTs
    logic        v8, cin8, sub8;
    logic [7:0]  a8, b8;
    logic        rdy8a, rdy8b, ov8a, ov8b, co8a, co8b, of8a, of8b;
    logic [7:0]  s8a, s8b;
    logic        v64, cin64, sub64, rdy64, ov64, co64, of64;
    logic [63:0] a64, b64, s64;
    logic        sweep_ready = 1'b1;

    cla_pipe_adder #(.WIDTH(32), .GROUP(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf)
    );

    cla_pipe_adder #(.WIDTH(8), .GROUP(1)) u_w8g1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8a),
        .in_a(a8), .in_b(b8), .in_cin(cin8), .in_sub(sub8),
        .out_valid(ov8a), .out_ready(sweep_ready), .out_sum(s8a),
        .out_cout(co8a), .out_ovf(of8a)
    );

    cla_pipe_adder #(.WIDTH(8), .GROUP(8)) u_w8g8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8b),
        .in_a(a8), .in_b(b8), .in_cin(cin8), .in_sub(sub8),
        .out_valid(ov8b), .out_ready(sweep_ready), .out_sum(s8b),
        .out_cout(co8b), .out_ovf(of8b)
    );

    cla_pipe_adder #(.WIDTH(64), .GROUP(8)) u_w64g8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64),
        .in_a(a64), .in_b(b64), .in_cin(cin64), .in_sub(sub64),
        .out_valid(ov64), .out_ready(sweep_ready), .out_sum(s64),
        .out_cout(co64), .out_ovf(of64)
    );

    res_t sb[$];
    res_t q8a[$];
    res_t q8b[$];
    res_t q64[$];

    int          n_out;
    bit          in_fired;
    bit          stalled_prev = 1'b0;
    logic [31:0] held_sum;

    // Reference: plain wide addition, independent of any lookahead structure.
    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        logic [63:0] mask, am, bm;
        logic [64:0] full;
        res_t        r;
        mask   = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am     = a & mask;
        bm     = (sub ? ~b : b) & mask;
        full   = {1'b0, am} + {1'b0, bm} + {64'd0, (sub | cin)};
        r.sum  = full[63:0] & mask;
        r.cout = full[w];
        r.ovf  = (am[w-1] == bm[w-1]) && (r.sum[w-1] != am[w-1]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, inout res_t q[$], input logic [63:0] s,
                             input logic c, input logic o);
        res_t e;
        check({tag, "_queue_nonempty"}, 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            check({tag, "_sum"}, s, e.sum);
            check({tag, "_cout"}, 64'(c), 64'(e.cout));
            check({tag, "_ovf"}, 64'(o), 64'(e.ovf));
        end
    endtask

    // One clock: sample handshakes between edges, then score transfers at the edge.
    task automatic cycle();
        bit          f_in, f_out, f8a, f8b, f8i, f64o, f64i;
        logic [31:0] s_obs;
        logic        c_obs, o_obs;
        #1;
        f_in  = in_valid && in_ready;
        f_out = out_valid && out_ready;
        s_obs = out_sum; c_obs = out_cout; o_obs = out_ovf;
        f8i   = v8 && rdy8a && rdy8b;
        f8a   = ov8a; f8b = ov8b;
        f64i  = v64 && rdy64; f64o = ov64;
        if (out_valid && !out_ready) begin
            if (stalled_prev) check("stall_sum_stable", 64'(out_sum), 64'(held_sum));
            held_sum     = out_sum;
            stalled_prev = 1'b1;
        end else begin
            stalled_prev = 1'b0;
        end
        @(posedge clk);
        in_fired = f_in;
        if (f_in) sb.push_back(model(32, 64'(in_a), 64'(in_b), in_cin, in_sub));
        if (f_out) begin
            $display("xfer out sum=%08h cout=%0d ovf=%0d", s_obs, c_obs, o_obs);
            pop_check("main", sb, 64'(s_obs), c_obs, o_obs);
            n_out++;
        end
        if (f8i) begin
            q8a.push_back(model(8, 64'(a8), 64'(b8), cin8, sub8));
            q8b.push_back(model(8, 64'(a8), 64'(b8), cin8, sub8));
        end
        if (f8a) pop_check("w8g1", q8a, 64'(s8a), co8a, of8a);
        if (f8b) pop_check("w8g8", q8b, 64'(s8b), co8b, of8b);
        if (f64i) q64.push_back(model(64, a64, b64, cin64, sub64));
        if (f64o) pop_check("w64g8", q64, s64, co64, of64);
        #1;
    endtask

    // Single transaction with an empty pipe: result must show exactly two edges after accept.
    task automatic send_expect(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic sub, input logic [31:0] es,
                               input logic ec, input logic eo);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check({tag, "_valid_after_1"}, 64'(out_valid), 64'd0);
        cycle();
        check({tag, "_valid_after_2"}, 64'(out_valid), 64'd1);
        check({tag, "_sum"}, 64'(out_sum), 64'(es));
        check({tag, "_cout"}, 64'(out_cout), 64'(ec));
        check({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
        cycle();
    endtask

    task automatic drain();
        in_valid = 1'b0; v8 = 1'b0; v64 = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        check("drain_main_empty", 64'(sb.size()), 64'd0);
        check("drain_w8g1_empty", 64'(q8a.size()), 64'd0);
        check("drain_w8g8_empty", 64'(q8b.size()), 64'd0);
        check("drain_w64_empty", 64'(q64.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        v64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0; sub64 = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_cout", 64'(out_cout), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Directed vectors
        send_expect("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        send_expect("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        send_expect("sub_borrow", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_expect("add_posovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send_expect("add_cin", 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h2143_6588, 1'b0, 1'b0);
        send_expect("sub_cin_ign", 32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0);

        // Backpressure: out_ready low for stream cycles 3..6
        begin
            int sent;
            sent = 0; n_out = 0;
            in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom); in_sub = 1'($urandom);
            for (int cyc = 0; cyc < 20; cyc++) begin
                out_ready = !(cyc >= 3 && cyc <= 6);
                in_valid  = (sent < 8);
                if (cyc == 6) begin
                    #1;
                    check("bp_in_ready_low", 64'(in_ready), 64'd0);
                end
                cycle();
                if (in_fired) begin
                    sent++;
                    in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom); in_sub = 1'($urandom);
                end
            end
            check("bp_results", 64'(n_out), 64'd8);
            check("bp_sb_empty", 64'(sb.size()), 64'd0);
        end

        // Reset with both stages full
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = $urandom; in_b = $urandom;
            cycle();
        end
        check("mid_full_valid", 64'(out_valid), 64'd1);
        check("mid_full_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
        stalled_prev = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_expect("post_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

        // Back-to-back streaming
        n_out = 0; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom); in_sub = 1'($urandom);
            #1;
            check("b2b_in_ready", 64'(in_ready), 64'd1);
            cycle();
        end
        check("b2b_results", 64'(n_out), 64'd998);
        drain();

        // Sweep: exhaustive 8-bit operands, random 64-bit operands
        v8 = 1'b1; v64 = 1'b1;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                a8 = 8'(a); b8 = 8'(b);
                cin8 = 1'($urandom); sub8 = 1'($urandom);
                a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
                cin64 = 1'($urandom); sub64 = 1'($urandom);
                cycle();
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
